// File: rtl/tick_shift_tx.sv
// tick_shift_tx: tick-paced, MSB-first, mode-0 serial shifter.
// A parallel word is taken over a valid/ready handshake, shifted out on sdo
// while sdi is captured into rx_data. sclk and cs_n advance only on tick.
//
//  state    | meaning
//  ---------+---------------------------------------------------------------
//  IDLE     | ready for a new word, cs_n high, ticks ignored
//  SETUP    | cs_n low, MSB already on sdo, waiting for the first rising sclk
//  HIGH     | sclk high, sdi sampled on entry, next tick drops sclk
//  LOW      | sclk low, next bit already on sdo, next tick raises sclk
//  HOLD     | last bit held on sdo, next tick closes the frame and pulses done
module tick_shift_tx #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 5
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             tick_i,
   input  logic             load_valid_i,
   output logic             load_ready_o,
   input  logic [WIDTH-1:0] tx_data_i,
   input  logic             sdi_i,
   output logic             sclk_o,
   output logic             cs_n_o,
   output logic             sdo_o,
   output logic [WIDTH-1:0] rx_data_o,
   output logic             done_o,
   output logic             busy_o
);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_SETUP = 3'd1;
   localparam logic [2:0] ST_HIGH  = 3'd2;
   localparam logic [2:0] ST_LOW   = 3'd3;
   localparam logic [2:0] ST_HOLD  = 3'd4;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [2:0]       state_q,   state_d;
   logic [WIDTH-1:0] tx_sh_q,   tx_sh_d;
   logic [WIDTH-1:0] rx_sh_q,   rx_sh_d;
   logic [WIDTH-1:0] rx_data_q, rx_data_d;
   logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic             sclk_q,    sclk_d;
   logic             cs_n_q,    cs_n_d;
   logic             sdo_q,     sdo_d;
   logic             done_q,    done_d;
   logic             busy_q,    busy_d;
   logic             ready_q,   ready_d;

   // Next-state and next-output decode; every output is produced from a register.
   always_comb begin
      state_d   = state_q;
      tx_sh_d   = tx_sh_q;
      rx_sh_d   = rx_sh_q;
      rx_data_d = rx_data_q;
      bit_cnt_d = bit_cnt_q;
      sclk_d    = sclk_q;
      cs_n_d    = cs_n_q;
      sdo_d     = sdo_q;
      busy_d    = busy_q;
      ready_d   = ready_q;
      done_d    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // A tick in the acceptance cycle is deliberately not used.
            if (load_valid_i && ready_q) begin
               tx_sh_d   = tx_data_i;
               bit_cnt_d = CNT_LAST;
               sdo_d     = tx_data_i[WIDTH-1];
               cs_n_d    = 1'b0;
               busy_d    = 1'b1;
               ready_d   = 1'b0;
               state_d   = ST_SETUP;
            end
         end
         ST_SETUP, ST_LOW: begin
            if (tick_i) begin
               sclk_d  = 1'b1;
               rx_sh_d = {rx_sh_q[WIDTH-2:0], sdi_i};
               state_d = ST_HIGH;
            end
         end
         ST_HIGH: begin
            if (tick_i) begin
               sclk_d = 1'b0;
               if (bit_cnt_q == '0) begin
                  state_d = ST_HOLD;
               end else begin
                  tx_sh_d   = tx_sh_q << 1;
                  sdo_d     = tx_sh_q[WIDTH-2];
                  bit_cnt_d = bit_cnt_q - CNT_ONE;
                  state_d   = ST_LOW;
               end
            end
         end
         ST_HOLD: begin
            if (tick_i) begin
               cs_n_d    = 1'b1;
               sdo_d     = 1'b0;
               rx_data_d = rx_sh_q;
               done_d    = 1'b1;
               busy_d    = 1'b0;
               ready_d   = 1'b1;
               state_d   = ST_IDLE;
            end
         end
         default: begin
            sclk_d  = 1'b0;
            cs_n_d  = 1'b1;
            sdo_d   = 1'b0;
            busy_d  = 1'b0;
            ready_d = 1'b1;
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers; reset silently abandons any frame in flight.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         tx_sh_q   <= '0;
         rx_sh_q   <= '0;
         rx_data_q <= '0;
         bit_cnt_q <= '0;
         sclk_q    <= 1'b0;
         cs_n_q    <= 1'b1;
         sdo_q     <= 1'b0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
         ready_q   <= 1'b1;
      end else begin
         state_q   <= state_d;
         tx_sh_q   <= tx_sh_d;
         rx_sh_q   <= rx_sh_d;
         rx_data_q <= rx_data_d;
         bit_cnt_q <= bit_cnt_d;
         sclk_q    <= sclk_d;
         cs_n_q    <= cs_n_d;
         sdo_q     <= sdo_d;
         done_q    <= done_d;
         busy_q    <= busy_d;
         ready_q   <= ready_d;
      end
   end

   assign load_ready_o = ready_q;
   assign sclk_o       = sclk_q;
   assign cs_n_o       = cs_n_q;
   assign sdo_o        = sdo_q;
   assign rx_data_o    = rx_data_q;
   assign done_o       = done_q;
   assign busy_o       = busy_q;

endmodule
